// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider; divisor reloads land on period boundaries.
// Optional SYNC phase-align input is built when PROG_CLOCK_DIVIDER_PHASE_ALIGN_EN is defined.
module prog_clock_divider #(
  parameter int               N_CH        = 2,
  parameter int               WIDTH       = 28,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(31250000)
) (
  input  logic             CLK_IN,
  input  logic             RST,
  input  logic [N_CH-1:0]  EN,
  input  logic             LOAD_VALID,
  input  logic [2:0]       LOAD_CH,
  input  logic [WIDTH-1:0] LOAD_DIV,
`ifdef PROG_CLOCK_DIVIDER_PHASE_ALIGN_EN
  input  logic             SYNC,
`endif
  output logic             LOAD_ERR,
  output logic [N_CH-1:0]  CLK_OUT,
  output logic [N_CH-1:0]  TICK
);

  localparam logic [3:0] N_CH_L = 4'(N_CH);

  logic load_bad;
  logic sync_req;

`ifdef PROG_CLOCK_DIVIDER_PHASE_ALIGN_EN
  assign sync_req = SYNC;
`else
  assign sync_req = 1'b0;
`endif

  assign load_bad = ({1'b0, LOAD_CH} >= N_CH_L) || (LOAD_DIV < WIDTH'(2));

  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) LOAD_ERR <= 1'b0;
    else     LOAD_ERR <= LOAD_VALID && load_bad;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_active;
    logic [WIDTH-1:0] div_pend;
    logic             pend_valid;
    logic             clk_q;
    logic             tick_q;
    logic             load_hit;
    logic             term;
    logic             apply;

    assign load_hit = LOAD_VALID && !load_bad && (LOAD_CH == 3'(i));
    assign term     = (cnt == div_active - WIDTH'(1));
    // A pending divisor may only take over where the phase restarts at zero.
    assign apply    = !EN[i] || sync_req || term;

    always_ff @(posedge CLK_IN or posedge RST) begin
      if (RST) begin
        cnt        <= '0;
        div_active <= DEFAULT_DIV;
        div_pend   <= DEFAULT_DIV;
        pend_valid <= 1'b0;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        if (!EN[i] || sync_req) begin
          cnt    <= '0;
          clk_q  <= 1'b0;
          tick_q <= 1'b0;
        end else begin
          clk_q <= (cnt < (div_active >> 1));
          if (term) begin
            cnt    <= '0;
            tick_q <= 1'b1;
          end else begin
            cnt    <= cnt + WIDTH'(1);
            tick_q <= 1'b0;
          end
        end
        if (apply && pend_valid) begin
          div_active <= div_pend;
          pend_valid <= 1'b0;
        end
        // A load on a boundary edge is parked here and waits for the next boundary.
        if (load_hit) begin
          div_pend   <= LOAD_DIV;
          pend_valid <= 1'b1;
        end
      end
    end

    assign CLK_OUT[i] = clk_q;
    assign TICK[i]    = tick_q;
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Self-checking bench for prog_clock_divider (N_CH=2, WIDTH=8, DEFAULT_DIV=4).
// Expected waveforms come from the period/duty rules; a scoreboard queue holds one record per edge.
module tb_prog_clock_divider;

  logic       CLK_IN = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] EN = 2'b00;
  logic       LOAD_VALID = 1'b0;
  logic [2:0] LOAD_CH = 3'd0;
  logic [7:0] LOAD_DIV = 8'd0;
  logic       SYNC = 1'b0;
  logic       LOAD_ERR;
  logic [1:0] CLK_OUT;
  logic [1:0] TICK;

  prog_clock_divider #(.N_CH(2), .WIDTH(8), .DEFAULT_DIV(8'd4)) dut (
    .CLK_IN(CLK_IN), .RST(RST), .EN(EN),
    .LOAD_VALID(LOAD_VALID), .LOAD_CH(LOAD_CH), .LOAD_DIV(LOAD_DIV),
`ifdef PROG_CLOCK_DIVIDER_PHASE_ALIGN_EN
    .SYNC(SYNC),
`endif
    .LOAD_ERR(LOAD_ERR), .CLK_OUT(CLK_OUT), .TICK(TICK)
  );

  always #5 CLK_IN = ~CLK_IN;

  typedef struct {
    logic [1:0] clk;
    logic [1:0] tick;
    logic       err;
  } exp_t;

  typedef struct {
    logic       valid;
    logic [2:0] ch;
    logic [7:0] div;
    logic       err;
  } ld_vec_t;

  exp_t    sb_q[$];
  ld_vec_t ld_tab[6];

  int n_chk  = 0;
  int n_fail = 0;

  // Expected phase position, current period and period after the next boundary.
  int   p[2];
  int   d[2];
  int   nd[2];
  logic [1:0] en_exp = 2'b11;
  logic       err_exp = 1'b0;
  logic       sync_exp = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      p[c] = 0; d[c] = 4; nd[c] = 4;
    end
  endtask

  task automatic cycle();
    exp_t e;
    exp_t got;
    for (int c = 0; c < 2; c++) begin
      if (!en_exp[c] || sync_exp) begin
        e.clk[c] = 1'b0; e.tick[c] = 1'b0;
        p[c] = 0; d[c] = nd[c];
      end else begin
        e.clk[c]  = (p[c] < d[c] / 2);
        e.tick[c] = (p[c] == d[c] - 1);
        if (p[c] == d[c] - 1) begin p[c] = 0; d[c] = nd[c]; end
        else p[c]++;
      end
    end
    e.err = err_exp;
    sb_q.push_back(e);
    EN   = en_exp;
    SYNC = sync_exp;
    @(posedge CLK_IN);
    #1;
    if (sb_q.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard_empty @%0t", $time);
    end else begin
      got = sb_q.pop_front();
      chk("clk_out", {6'd0, CLK_OUT}, {6'd0, got.clk});
      chk("tick", {6'd0, TICK}, {6'd0, got.tick});
      chk("load_err", {7'd0, LOAD_ERR}, {7'd0, got.err});
    end
    err_exp = 1'b0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_load(input logic v, input logic [2:0] ch, input logic [7:0] dv, input logic er);
    LOAD_VALID = v; LOAD_CH = ch; LOAD_DIV = dv;
    err_exp = er;
    cycle();
    LOAD_VALID = 1'b0;
    if (v && !er) nd[ch] = int'(dv);
  endtask

  task automatic wait_pos(input int ch, input int pos, input string name);
    for (int k = 0; k < 20 && p[ch] != pos; k++) cycle();
    if (p[ch] != pos) begin
      n_chk++; n_fail++;
      $display("FAIL %s: position %0d not reached", name, pos);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    ld_tab[0] = '{valid: 1'b1, ch: 3'd3, div: 8'd5, err: 1'b1};
    ld_tab[1] = '{valid: 1'b1, ch: 3'd1, div: 8'd1, err: 1'b1};
    ld_tab[2] = '{valid: 1'b1, ch: 3'd0, div: 8'd0, err: 1'b1};
    ld_tab[3] = '{valid: 1'b1, ch: 3'd2, div: 8'd4, err: 1'b1};
    ld_tab[4] = '{valid: 1'b0, ch: 3'd3, div: 8'd1, err: 1'b0};
    ld_tab[5] = '{valid: 1'b1, ch: 3'd0, div: 8'd4, err: 1'b0};

    // Reset state, with a load presented during reset that must be ignored.
    model_reset();
    EN = 2'b11;
    LOAD_VALID = 1'b1; LOAD_CH = 3'd0; LOAD_DIV = 8'd5;
    for (int k = 0; k < 2; k++) begin
      @(posedge CLK_IN); #1;
      chk("rst_clk_out", {6'd0, CLK_OUT}, 8'd0);
      chk("rst_tick", {6'd0, TICK}, 8'd0);
      chk("rst_load_err", {7'd0, LOAD_ERR}, 8'd0);
    end
    RST = 1'b0;
    LOAD_VALID = 1'b0;

    // Default divide-by-4 on both channels.
    run(9);

    // Mid-period load of ch1 = 6; ch0 keeps running at 4.
    do_load(1'b1, 3'd1, 8'd6, 1'b0);
    run(15);

    // ch0 = 5 loaded on its own terminal-count edge: one more period of 4 first.
    wait_pos(0, 3, "align_tc0");
    do_load(1'b1, 3'd0, 8'd5, 1'b0);
    run(16);

    // Two back-to-back loads to ch1: the later one wins.
    do_load(1'b1, 3'd1, 8'd3, 1'b0);
    do_load(1'b1, 3'd1, 8'd7, 1'b0);
    run(16);

    // Rejected / ignored loads, then ch0 back to 4.
    for (int k = 0; k < 6; k++)
      do_load(ld_tab[k].valid, ld_tab[k].ch, ld_tab[k].div, ld_tab[k].err);
    run(12);

    // Disable ch0 for three cycles in its high phase, then restart from zero.
    wait_pos(0, 1, "align_high0");
    en_exp[0] = 1'b0;
    run(3);
    en_exp[0] = 1'b1;
    run(8);

    // Load while disabled is applied before the channel restarts.
    en_exp[0] = 1'b0;
    cycle();
    do_load(1'b1, 3'd0, 8'd6, 1'b0);
    cycle();
    en_exp[0] = 1'b1;
    run(12);

    // Async reset mid-period with a pending ch1 load that must be dropped.
    wait_pos(0, 1, "align_high0_rst");
    do_load(1'b1, 3'd1, 8'd2, 1'b0);
    RST = 1'b1;
    #2;
    chk("async_rst_clk_out", {6'd0, CLK_OUT}, 8'd0);
    chk("async_rst_tick", {6'd0, TICK}, 8'd0);
    @(posedge CLK_IN); #1;
    RST = 1'b0;
    model_reset();
    run(16);

`ifdef PROG_CLOCK_DIVIDER_PHASE_ALIGN_EN
    do_load(1'b1, 3'd1, 8'd6, 1'b0);
    run(10);
    sync_exp = 1'b1;
    cycle();
    sync_exp = 1'b0;
    run(12);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
